// File: rtl/mux_address_bus_pkg.sv
// Shared defaults, select encodings and PC zero-extension helper for mux_address_bus.
package mux_address_bus_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned PC_W_DEF   = 8;

    localparam logic SEL_PC  = 1'b1;
    localparam logic SEL_BUS = 1'b0;

    // Zero-extend a default-width PC address to the default address-bus width.
    function automatic logic [ADDR_W_DEF-1:0] zext_pc(input logic [PC_W_DEF-1:0] pc);
        return ADDR_W_DEF'(pc);
    endfunction

endpackage

// File: rtl/mux_address_sel.sv
// Combinational source select: zero-extended PC address or the data address bus.
module mux_address_sel
    import mux_address_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned PC_W   = PC_W_DEF
) (
    input  logic              sel,
    input  logic [PC_W-1:0]   pc_addr,
    input  logic [ADDR_W-1:0] bus_addr,
    output logic [ADDR_W-1:0] next_addr_c
);

    logic [ADDR_W-1:0] pc_ext;

    // Default widths use the shared helper; other widths extend by an unsigned cast.
    if (ADDR_W == ADDR_W_DEF && PC_W == PC_W_DEF) begin : g_ext_def
        assign pc_ext = zext_pc(pc_addr);
    end else begin : g_ext_gen
        assign pc_ext = ADDR_W'(pc_addr);
    end

    // Explicit if/else so the unselected source never reaches the output.
    always_comb begin
        next_addr_c = bus_addr;
        if (sel == SEL_PC) begin
            next_addr_c = pc_ext;
        end
    end

endmodule

// File: rtl/mux_address_bus.sv
// Registered 2:1 memory address source selector with a travelling source flag.
// Optional even-parity output is compiled in with `define MUX_ADDR_BUS_PARITY_EN.
module mux_address_bus
    import mux_address_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned PC_W   = PC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sel,
    input  logic [PC_W-1:0]   pc_addr,
    input  logic [ADDR_W-1:0] bus_addr,
    output logic [ADDR_W-1:0] addr_out,
`ifdef MUX_ADDR_BUS_PARITY_EN
    output logic              src_pc,
    output logic              addr_par
`else
    output logic              src_pc
`endif
);

    // Reject PC widths that cannot be zero-extended into the address bus.
    if (PC_W == 0 || PC_W > ADDR_W) begin : g_bad_width
        $error("mux_address_bus: PC_W must satisfy 1 <= PC_W <= ADDR_W");
    end

    logic [ADDR_W-1:0] next_addr_c;

    mux_address_sel #(
        .ADDR_W (ADDR_W),
        .PC_W   (PC_W)
    ) u_sel (
        .sel         (sel),
        .pc_addr     (pc_addr),
        .bus_addr    (bus_addr),
        .next_addr_c (next_addr_c)
    );

    // Capture the selected address and its source on enabled edges; hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_out <= '0;
            src_pc   <= 1'b0;
        end else if (en) begin
            addr_out <= next_addr_c;
            src_pc   <= sel;
        end
    end

`ifdef MUX_ADDR_BUS_PARITY_EN
    // Parity is computed from the next address so it lines up with addr_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_par <= 1'b0;
        end else if (en) begin
            addr_par <= ^next_addr_c;
        end
    end
`endif

endmodule

// File: tb/tb_mux_address_bus.sv
// Scoreboard bench for mux_address_bus: driver pushes expected outputs, monitor pops and compares.
module tb_mux_address_bus;
    import mux_address_bus_pkg::*;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned PC_W   = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              sel = 1'b0;
    logic [PC_W-1:0]   pc_addr = '0;
    logic [ADDR_W-1:0] bus_addr = '0;
    logic [ADDR_W-1:0] addr_out;
    logic              src_pc;
`ifdef MUX_ADDR_BUS_PARITY_EN
    logic              addr_par;
`endif

    mux_address_bus #(
        .ADDR_W (ADDR_W),
        .PC_W   (PC_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sel      (sel),
        .pc_addr  (pc_addr),
        .bus_addr (bus_addr),
        .addr_out (addr_out),
`ifdef MUX_ADDR_BUS_PARITY_EN
        .src_pc   (src_pc),
        .addr_par (addr_par)
`else
        .src_pc   (src_pc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              src;
        logic              par;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned m_addr = 0;
    bit          m_src = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    // One clock of stimulus: inputs change on the falling edge, expectation is queued.
    task automatic step(input bit r, input bit e, input bit s, input int unsigned pc, input int unsigned bus);
        exp_t x;
        @(negedge clk);
        rst_n    = r;
        en       = e;
        sel      = s;
        pc_addr  = PC_W'(pc);
        bus_addr = ADDR_W'(bus);
        if (!r) begin
            m_addr = 0;
            m_src  = 1'b0;
        end else if (e) begin
            m_addr = s ? (pc % (1 << PC_W)) : (bus % (1 << ADDR_W));
            m_src  = s;
        end
        x.addr = ADDR_W'(m_addr);
        x.src  = m_src;
        x.par  = ($countones(m_addr) % 2) == 1;
        sb.push_back(x);
    endtask

    // Monitor: compare DUT outputs against the queued expectation after each edge.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check("addr_out", 32'(addr_out), 32'(x.addr));
            check("src_pc", 32'(src_pc), 32'(x.src));
`ifdef MUX_ADDR_BUS_PARITY_EN
            check("addr_par", 32'(addr_par), 32'(x.par));
`endif
        end
    end

    task automatic check_zero_now(input string tag);
        check({tag, "_addr"}, 32'(addr_out), 32'h0);
        check({tag, "_src"}, 32'(src_pc), 32'h0);
`ifdef MUX_ADDR_BUS_PARITY_EN
        check({tag, "_par"}, 32'(addr_par), 32'h0);
`endif
    endtask

    initial begin
        // Reset held from time 0 with random, enabled inputs: outputs must be zero before any edge.
        en = 1'b1;
        sel = 1'($urandom);
        pc_addr = PC_W'($urandom);
        bus_addr = ADDR_W'($urandom);
        #2;
        check_zero_now("reset_init");
        repeat (3) step(1'b0, 1'b1, 1'($urandom), $urandom, $urandom);

        // Released but not enabled: outputs stay at reset values.
        repeat (3) step(1'b1, 1'b0, 1'($urandom), $urandom, $urandom);

        // Bus path and PC path with zero extension.
        step(1'b1, 1'b1, SEL_BUS, 32'h01, 32'h0324);
        step(1'b1, 1'b1, SEL_PC, 32'h06, 32'h4125);
        step(1'b1, 1'b1, SEL_PC, 32'h9C, 32'hFFFF);
        step(1'b1, 1'b1, SEL_PC, 32'hFF, 32'h1234);
        step(1'b1, 1'b1, SEL_BUS, 32'hFF, 32'hFFFF);

        // Hold: load 0x0324 then disable with PC selected.
        step(1'b1, 1'b1, SEL_BUS, 32'h01, 32'h0324);
        repeat (3) step(1'b1, 1'b0, SEL_PC, 32'h0A, 32'h5555);

        // Back-to-back toggle with no bubble.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, (i % 2) == 1, 32'h0A, 32'h0324);

        // Parity corner values.
        step(1'b1, 1'b1, SEL_BUS, 32'h00, 32'h0324);
        step(1'b1, 1'b1, SEL_BUS, 32'h00, 32'h0325);
        step(1'b1, 1'b1, SEL_BUS, 32'h00, 32'h0000);

        // Randomised traffic.
        for (int i = 0; i < 300; i++)
            step(1'b1, ($urandom % 4) != 0, 1'($urandom), $urandom, $urandom);

        // Asynchronous reset mid-cycle, away from any rising edge.
        step(1'b1, 1'b1, SEL_BUS, 32'h00, 32'hBEEF);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_now("reset_async");
        m_addr = 0;
        m_src  = 1'b0;
        repeat (2) step(1'b0, 1'b1, 1'($urandom), $urandom, $urandom);
        repeat (2) step(1'b1, 1'b0, 1'($urandom), $urandom, $urandom);

        for (int i = 0; i < 100; i++)
            step(1'b1, ($urandom % 3) != 0, 1'($urandom), $urandom, $urandom);

        repeat (2) @(negedge clk);
        check("scoreboard_drain", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_address_bus.md
# mux_address_bus

Registered 2:1 address-bus source selector for the memory-control path. Each enabled cycle it selects either the zero-extended program-counter (instruction fetch) address or the full-width data address bus, and presents the result on the memory address bus one cycle later. A source flag travels with the address. An optional parity bit can be compiled in.

## Interface
Parameters:
- ADDR_W, 16: address bus width.
- PC_W, 8: PC address width. Legal range is 1 ≤ PC_W ≤ ADDR_W; elaboration fails otherwise.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- en  input  1  capture enable; when 0, outputs hold their values.
- sel  input  1  source select: 1 = PC address, 0 = data address bus.
- pc_addr  input  PC_W  instruction-fetch address.
- bus_addr  input  ADDR_W  data address bus input.
- addr_out  output  ADDR_W  registered selected address.
- src_pc  output  1  registered flag; 1 when addr_out came from pc_addr.
- addr_par  output  1  even parity of addr_out. Present only with MUX_ADDR_BUS_PARITY_EN.

## Operation
- Next value when sel=1: {(ADDR_W-PC_W) zero bits, pc_addr}. Zero extension only; never sign extension.
- Next value when sel=0: bus_addr, passed unmodified.
- src_pc next value equals sel.
- en=1: addr_out, src_pc and addr_par load their next values.
- en=0: all registered outputs hold. sel and the address inputs are ignored.
- No arithmetic is performed. Output width always equals ADDR_W.
- X on the unselected input must not propagate to addr_out.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- No handshake. en is the only qualifier.
- Asynchronous reset (rst_n=0) immediately forces addr_out=0, src_pc=0 and addr_par=0, regardless of clk.
- Outputs stay at their reset values until the first rising edge with en=1 after rst_n deasserts.
- Reset asserted mid-stream clears the outputs; no pending value survives reset.
- sel toggling every cycle with en=1: output follows it cycle-for-cycle with no bubble.
- When PC_W=ADDR_W there is no extension; pc_addr passes straight through.

## Configuration
- Macro MUX_ADDR_BUS_PARITY_EN.
- Defined: the addr_par port exists. It is registered together with addr_out (XOR-reduce of the selected next address), so it equals ^addr_out every cycle, including 0 after reset.
- Undefined: the addr_par port and its register are absent. All other behaviour is identical.

## Structure
- Package mux_address_bus_pkg holds:
  - defaults ADDR_W_DEF=16 and PC_W_DEF=8;
  - constants SEL_PC=1'b1 and SEL_BUS=1'b0;
  - a function zext_pc(pc) returning the ADDR_W-wide zero-extended value.
- One combinational sub-module, mux_address_sel, does the selection and extension and produces next_addr.
- The top level holds the registers, enable and reset logic, and the optional parity.

## Test plan
- Reset: rst_n=0 with random inputs -> addr_out=0x0000, src_pc=0 (addr_par=0) immediately; outputs unchanged after release until the first en=1 edge.
- Bus path: en=1, sel=0, pc_addr=0x01, bus_addr=0x0324 -> after one edge, addr_out=0x0324, src_pc=0.
- PC path: en=1, sel=1, pc_addr=0x06, bus_addr=0x4125 -> addr_out=0x0006, src_pc=1. Then pc_addr=0x9C -> addr_out=0x009C (upper byte zero).
- Hold: load 0x0324, then en=0 with sel=1 and pc_addr=0x0A -> addr_out stays 0x0324 for 3 cycles.
- Back-to-back toggle: sel alternating 0/1 with bus_addr=0x0324 and pc_addr=0x0A -> addr_out alternates 0x0324/0x000A with 1-cycle lag.
- Parity (macro defined): bus_addr=0x0324 -> addr_par=0. bus_addr=0x0325 -> addr_par=1.
